// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX->MEM register, data-memory req/gnt/rvalid FSM, load/store lane handling.
// Optional macro MEM_MISALIGNED_TRAP_EN: misaligned HALF/WORD accesses trap instead of being issued with a truncated offset.
module mem_stage #(
    parameter int ISA_F  = 0,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        rd_addr_ex_i,
    input  logic              rd_dst_bank_ex_i,
    input  logic [31:0]       alu_result_ex_i,
    input  logic              mem_wen_ex_i,
    input  logic [1:0]        mem_data_type_ex_i,
    input  logic              mem_sign_extend_ex_i,
    input  logic [31:0]       mem_wdata_ex_i,
    input  logic              reg_alu_wen_ex_i,
    input  logic              reg_mem_wen_ex_i,
    input  logic              valid_ex_i,
    input  logic [31:0]       pc_ex_i,
    input  logic              stall_mem_i,
    input  logic              flush_mem_i,
    output logic              dmem_req_o,
    input  logic              dmem_gnt_i,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic [4:0]        rd_addr_mem_o,
    output logic              rd_dst_bank_mem_o,
    output logic              reg_wen_mem_o,
    output logic [31:0]       wdata_mem_o,
    output logic              valid_mem_o,
    output logic              mem_busy_o,
    output logic              trap_mem_o,
    output logic [4:0]        trap_cause_mem_o,
    output logic [31:0]       trap_tval_mem_o,
    output logic [31:0]       pc_mem_o,
    output logic [1:0]        fsm_state_o
);

    localparam logic       X_REG = 1'b0;
    localparam logic [1:0] BYTE  = 2'd0;
    localparam logic [1:0] HALF  = 2'd1;
    localparam logic [1:0] WORD  = 2'd2;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_GNT = 2'd1, WAIT_RVALID = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        valid_q, bank_q, mem_wen_q, sext_q, alu_wen_q, mem_ren_q;
    logic        done_q, drop_q;
    logic [4:0]  rd_q;
    logic [1:0]  type_q;
    logic [31:0] alu_q, wdata_q, pc_q;

    logic        live, is_mem, misaligned, access, rsp, kill, withdraw, load_en, complete;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] bus_wdata, shifted, load_data;

    assign live   = valid_q & ~done_q;
    assign is_mem = mem_wen_q | mem_ren_q;

`ifdef MEM_MISALIGNED_TRAP_EN
    assign misaligned = ((type_q == HALF) & alu_q[0]) | ((type_q == WORD) & (alu_q[1:0] != 2'b00));
    assign off        = alu_q[1:0];
`else
    assign misaligned = 1'b0;
    assign off        = (type_q == WORD) ? 2'b00 : (type_q == HALF) ? {alu_q[1], 1'b0} : alu_q[1:0];
`endif

    // Bus handshake: an address phase is accepted in the cycle where req && gnt are both high; until then
    // req, we, be, addr and wdata stay stable. Each accepted request gets exactly one rvalid in a later cycle
    // (loads and stores alike). rvalid is only honoured in WAIT_RVALID, so at most one access is in flight.
    assign access     = live & is_mem & ~misaligned;
    assign rsp        = (state_q == WAIT_RVALID) & dmem_rvalid_i;
    assign mem_busy_o = access & ~rsp;
    assign dmem_req_o = access & (state_q != WAIT_RVALID);
    assign kill       = flush_mem_i & ~stall_mem_i;
    assign withdraw   = kill & dmem_req_o & ~dmem_gnt_i;
    assign load_en    = ~stall_mem_i & ~mem_busy_o;
    assign complete   = live & (access ? rsp : 1'b1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dmem_req_o && dmem_gnt_i)     state_d = WAIT_RVALID;
                else if (dmem_req_o && !withdraw) state_d = WAIT_GNT;
            end
            WAIT_GNT: begin
                if (dmem_req_o && dmem_gnt_i)     state_d = WAIT_RVALID;
                else if (withdraw || !dmem_req_o) state_d = IDLE;
            end
            WAIT_RVALID: if (dmem_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A flushed instruction whose request was already granted stays in place (drop_q) until its response drains.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            mem_wen_q <= 1'b0;
            alu_wen_q <= 1'b0;
            mem_ren_q <= 1'b0;
            rd_q      <= 5'd0;
            bank_q    <= X_REG;
            alu_q     <= 32'd0;
            wdata_q   <= 32'd0;
            pc_q      <= 32'd0;
            type_q    <= WORD;
            sext_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else if (load_en) begin
            valid_q   <= valid_ex_i & ~flush_mem_i;
            mem_wen_q <= mem_wen_ex_i & ~flush_mem_i;
            alu_wen_q <= reg_alu_wen_ex_i & ~flush_mem_i;
            mem_ren_q <= reg_mem_wen_ex_i & ~flush_mem_i;
            rd_q      <= rd_addr_ex_i;
            bank_q    <= (ISA_F != 0) ? rd_dst_bank_ex_i : X_REG;
            alu_q     <= alu_result_ex_i;
            wdata_q   <= mem_wdata_ex_i;
            pc_q      <= pc_ex_i;
            type_q    <= mem_data_type_ex_i;
            sext_q    <= mem_sign_extend_ex_i;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            if (withdraw) begin
                valid_q   <= 1'b0;
                mem_wen_q <= 1'b0;
                alu_wen_q <= 1'b0;
                mem_ren_q <= 1'b0;
            end else if (kill && mem_busy_o) begin
                drop_q <= 1'b1;
            end
            if (complete) done_q <= 1'b1;
        end
    end

    always_comb begin
        be        = 4'b1111;
        bus_wdata = wdata_q;
        load_data = shifted;
        case (type_q)
            BYTE: begin
                be        = 4'b0001 << off;
                bus_wdata = {4{wdata_q[7:0]}};
                load_data = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                be        = 4'b0011 << off;
                bus_wdata = {2{wdata_q[15:0]}};
                load_data = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    assign shifted      = dmem_rdata_i >> {off, 3'b000};
    assign dmem_we_o    = dmem_req_o & mem_wen_q;
    assign dmem_be_o    = dmem_req_o ? be : 4'b0000;
    assign dmem_addr_o  = dmem_req_o ? {alu_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wdata_o = dmem_req_o ? bus_wdata : 32'd0;

`ifdef MEM_MISALIGNED_TRAP_EN
    assign trap_mem_o       = live & is_mem & misaligned;
    assign trap_cause_mem_o = trap_mem_o ? (mem_wen_q ? 5'd6 : 5'd4) : 5'd0;
    assign trap_tval_mem_o  = trap_mem_o ? alu_q : 32'd0;
`else
    assign trap_mem_o       = 1'b0;
    assign trap_cause_mem_o = 5'd0;
    assign trap_tval_mem_o  = 32'd0;
`endif

    assign valid_mem_o       = complete & ~drop_q;
    assign reg_wen_mem_o     = valid_mem_o & (alu_wen_q | mem_ren_q) & ~trap_mem_o;
    assign wdata_mem_o       = mem_ren_q ? load_data : alu_q;
    assign rd_addr_mem_o     = rd_q;
    assign rd_dst_bank_mem_o = bank_q;
    assign pc_mem_o          = pc_q;
    assign fsm_state_o       = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: bus handshakes, lane handling, flush/reset during transactions, ALU retire.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  rd_addr_ex_i;
    logic        rd_dst_bank_ex_i;
    logic [31:0] alu_result_ex_i;
    logic        mem_wen_ex_i;
    logic [1:0]  mem_data_type_ex_i;
    logic        mem_sign_extend_ex_i;
    logic [31:0] mem_wdata_ex_i;
    logic        reg_alu_wen_ex_i;
    logic        reg_mem_wen_ex_i;
    logic        valid_ex_i;
    logic [31:0] pc_ex_i;
    logic        stall_mem_i;
    logic        flush_mem_i;
    logic        dmem_req_o;
    logic        dmem_gnt_i;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [4:0]  rd_addr_mem_o;
    logic        rd_dst_bank_mem_o;
    logic        reg_wen_mem_o;
    logic [31:0] wdata_mem_o;
    logic        valid_mem_o;
    logic        mem_busy_o;
    logic        trap_mem_o;
    logic [4:0]  trap_cause_mem_o;
    logic [31:0] trap_tval_mem_o;
    logic [31:0] pc_mem_o;
    logic [1:0]  fsm_state_o;

    int tests = 0;
    int fails = 0;
    int gnt_cnt = 0;
    int gnt_base;
    logic [31:0] exp_q[$];

    mem_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_addr_ex_i(rd_addr_ex_i), .rd_dst_bank_ex_i(rd_dst_bank_ex_i),
        .alu_result_ex_i(alu_result_ex_i), .mem_wen_ex_i(mem_wen_ex_i),
        .mem_data_type_ex_i(mem_data_type_ex_i), .mem_sign_extend_ex_i(mem_sign_extend_ex_i),
        .mem_wdata_ex_i(mem_wdata_ex_i), .reg_alu_wen_ex_i(reg_alu_wen_ex_i),
        .reg_mem_wen_ex_i(reg_mem_wen_ex_i), .valid_ex_i(valid_ex_i), .pc_ex_i(pc_ex_i),
        .stall_mem_i(stall_mem_i), .flush_mem_i(flush_mem_i),
        .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
        .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .rd_addr_mem_o(rd_addr_mem_o), .rd_dst_bank_mem_o(rd_dst_bank_mem_o),
        .reg_wen_mem_o(reg_wen_mem_o), .wdata_mem_o(wdata_mem_o), .valid_mem_o(valid_mem_o),
        .mem_busy_o(mem_busy_o), .trap_mem_o(trap_mem_o), .trap_cause_mem_o(trap_cause_mem_o),
        .trap_tval_mem_o(trap_tval_mem_o), .pc_mem_o(pc_mem_o), .fsm_state_o(fsm_state_o)
    );

    // Clock and handshake monitor
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (!rst_i && dmem_req_o && dmem_gnt_i) gnt_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed=%h expected=<empty queue>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic drive_idle();
        valid_ex_i           = 1'b0;
        mem_wen_ex_i         = 1'b0;
        reg_alu_wen_ex_i     = 1'b0;
        reg_mem_wen_ex_i     = 1'b0;
        rd_addr_ex_i         = 5'd0;
        rd_dst_bank_ex_i     = 1'b0;
        alu_result_ex_i      = 32'd0;
        mem_data_type_ex_i   = 2'd2;
        mem_sign_extend_ex_i = 1'b0;
        mem_wdata_ex_i       = 32'd0;
        pc_ex_i              = 32'd0;
    endtask

    task automatic drive_ex(input logic [4:0] rd, input logic [31:0] alu, input logic wen,
                            input logic [1:0] dt, input logic sext, input logic [31:0] wd,
                            input logic alu_wen, input logic mem_ren, input logic [31:0] pc);
        valid_ex_i           = 1'b1;
        rd_addr_ex_i         = rd;
        rd_dst_bank_ex_i     = 1'b1;
        alu_result_ex_i      = alu;
        mem_wen_ex_i         = wen;
        mem_data_type_ex_i   = dt;
        mem_sign_extend_ex_i = sext;
        mem_wdata_ex_i       = wd;
        reg_alu_wen_ex_i     = alu_wen;
        reg_mem_wen_ex_i     = mem_ren;
        pc_ex_i              = pc;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] alu, input logic wen,
                         input logic [1:0] dt, input logic sext, input logic [31:0] wd,
                         input logic alu_wen, input logic mem_ren, input logic [31:0] pc);
        next_cycle();
        drive_ex(rd, alu, wen, dt, sext, wd, alu_wen, mem_ren, pc);
        settle();
    endtask

    // Holds gnt low for delay cycles, grants, then returns in the rvalid cycle with rvalid still high.
    task automatic bus_access(input int delay, input logic [31:0] addr, input logic [3:0] be,
                              input logic we, input logic [31:0] wd, input logic [31:0] rdata);
        for (int i = 0; i <= delay; i++) begin
            next_cycle();
            drive_idle();
            dmem_gnt_i    = (i == delay);
            dmem_rvalid_i = 1'b0;
            settle();
            check("req_held", dmem_req_o, 1'b1);
            check("addr", dmem_addr_o, addr);
            check("be", dmem_be_o, be);
            check("we", dmem_we_o, we);
            check("bus_wdata", dmem_wdata_o, wd);
            check("busy_req", mem_busy_o, 1'b1);
        end
        next_cycle();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        settle();
        check("req_rsp", dmem_req_o, 1'b0);
        check("busy_rsp", mem_busy_o, 1'b0);
    endtask

    task automatic quiet();
        next_cycle();
        drive_idle();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
        flush_mem_i   = 1'b0;
        stall_mem_i   = 1'b0;
        rst_i         = 1'b0;
        settle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, dmem_req_o, 1'b0);
        check({tag, "_busy"}, mem_busy_o, 1'b0);
        check({tag, "_valid"}, valid_mem_o, 1'b0);
        check({tag, "_rwen"}, reg_wen_mem_o, 1'b0);
        check({tag, "_wdata"}, wdata_mem_o, 32'd0);
        check({tag, "_bank"}, rd_dst_bank_mem_o, 1'b0);
        check({tag, "_trap"}, trap_mem_o, 1'b0);
        check({tag, "_state"}, fsm_state_o, 2'd0);
    endtask

    initial begin
        rst_i         = 1'b1;
        stall_mem_i   = 1'b0;
        flush_mem_i   = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
        drive_idle();
        repeat (2) @(posedge clk_i);
        settle();
        check_reset_outputs("rst");
        quiet();
        check_reset_outputs("post_rst");

        // Store byte at 0x1003, zero-wait memory
        gnt_base = gnt_cnt;
        issue(5'd0, 32'h0000_1003, 1'b1, 2'd0, 1'b0, 32'h0000_00AB, 1'b0, 1'b0, 32'h0000_0040);
        bus_access(0, 32'h0000_1000, 4'b1000, 1'b1, 32'hABAB_ABAB, 32'd0);
        check("st_valid", valid_mem_o, 1'b1);
        check("st_rwen", reg_wen_mem_o, 1'b0);
        check("st_pc", pc_mem_o, 32'h0000_0040);
        check("st_one_txn", gnt_cnt - gnt_base, 1);
        quiet();
        check("st_after_valid", valid_mem_o, 1'b0);

        // Signed and zero-extended half loads at 0x2002
        issue(5'd5, 32'h0000_2002, 1'b0, 2'd1, 1'b1, 32'd0, 1'b0, 1'b1, 32'h0000_0044);
        bus_access(0, 32'h0000_2000, 4'b1100, 1'b0, 32'd0, 32'h8001_1234);
        exp_q.push_back(32'hFFFF_8001);
        check_pop("lh_data", wdata_mem_o);
        check("lh_rwen", reg_wen_mem_o, 1'b1);
        check("lh_valid", valid_mem_o, 1'b1);
        check("lh_rd", rd_addr_mem_o, 5'd5);
        check("lh_bank_forced", rd_dst_bank_mem_o, 1'b0);
        quiet();
        issue(5'd6, 32'h0000_2002, 1'b0, 2'd1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0048);
        bus_access(0, 32'h0000_2000, 4'b1100, 1'b0, 32'd0, 32'h8001_1234);
        exp_q.push_back(32'h0000_8001);
        check_pop("lhu_data", wdata_mem_o);
        check("lhu_rwen", reg_wen_mem_o, 1'b1);
        quiet();

        // Word load with grant delayed 3 cycles
        gnt_base = gnt_cnt;
        issue(5'd7, 32'h0000_4000, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_004C);
        bus_access(3, 32'h0000_4000, 4'b1111, 1'b0, 32'd0, 32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        check_pop("lw_data", wdata_mem_o);
        check("lw_rwen", reg_wen_mem_o, 1'b1);
        check("lw_one_txn", gnt_cnt - gnt_base, 1);
        quiet();

        // Misaligned word load at 0x3001
        issue(5'd8, 32'h0000_3001, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0050);
`ifdef MEM_MISALIGNED_TRAP_EN
        next_cycle();
        drive_idle();
        settle();
        check("mis_trap", trap_mem_o, 1'b1);
        check("mis_cause", trap_cause_mem_o, 5'd4);
        check("mis_tval", trap_tval_mem_o, 32'h0000_3001);
        check("mis_req", dmem_req_o, 1'b0);
        check("mis_rwen", reg_wen_mem_o, 1'b0);
`else
        bus_access(0, 32'h0000_3000, 4'b1111, 1'b0, 32'd0, 32'h1122_3344);
        check("mis_trap", trap_mem_o, 1'b0);
        check("mis_data", wdata_mem_o, 32'h1122_3344);
        check("mis_rwen", reg_wen_mem_o, 1'b1);
`endif
        quiet();

        // Flush while waiting for rvalid
        issue(5'd9, 32'h0000_5000, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0054);
        next_cycle();
        drive_idle();
        dmem_gnt_i = 1'b1;
        settle();
        check("fl_req", dmem_req_o, 1'b1);
        next_cycle();
        dmem_gnt_i  = 1'b0;
        flush_mem_i = 1'b1;
        settle();
        check("fl_state", fsm_state_o, 2'd2);
        check("fl_busy", mem_busy_o, 1'b1);
        next_cycle();
        flush_mem_i   = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5555_AAAA;
        settle();
        check("fl_valid", valid_mem_o, 1'b0);
        check("fl_rwen", reg_wen_mem_o, 1'b0);
        check("fl_busy_rsp", mem_busy_o, 1'b0);
        quiet();
        check("fl_idle", fsm_state_o, 2'd0);
        check("fl_no_req", dmem_req_o, 1'b0);

        // Back-to-back ALU ops
        issue(5'd1, 32'h0000_0011, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0060);
        exp_q.push_back(32'h0000_0011);
        issue(5'd2, 32'h0000_0022, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0064);
        exp_q.push_back(32'h0000_0022);
        check("alu0_valid", valid_mem_o, 1'b1);
        check("alu0_rwen", reg_wen_mem_o, 1'b1);
        check_pop("alu0_data", wdata_mem_o);
        issue(5'd3, 32'h0000_0033, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0068);
        exp_q.push_back(32'h0000_0033);
        check("alu1_valid", valid_mem_o, 1'b1);
        check_pop("alu1_data", wdata_mem_o);
        check("alu1_pc", pc_mem_o, 32'h0000_0064);
        quiet();
        check("alu2_valid", valid_mem_o, 1'b1);
        check("alu2_rd", rd_addr_mem_o, 5'd3);
        check_pop("alu2_data", wdata_mem_o);
        quiet();
        check("alu_end_valid", valid_mem_o, 1'b0);

        // Reset while in WAIT_GNT, then a stray rvalid
        issue(5'd4, 32'h0000_6000, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0070);
        next_cycle();
        drive_idle();
        settle();
        check("rg_req0", dmem_req_o, 1'b1);
        next_cycle();
        settle();
        check("rg_state", fsm_state_o, 2'd1);
        check("rg_req1", dmem_req_o, 1'b1);
        next_cycle();
        rst_i = 1'b1;
        settle();
        next_cycle();
        rst_i = 1'b0;
        settle();
        check_reset_outputs("rg");
        next_cycle();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hCAFE_F00D;
        settle();
        check("stray_valid", valid_mem_o, 1'b0);
        check("stray_busy", mem_busy_o, 1'b0);
        check("stray_state", fsm_state_o, 2'd0);
        quiet();

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
